nist_pattern_source: RTL and testbench
======================================

// Module: nist_pattern_source
// PURPOSE
//  Deterministic bit-stream source for the NIST SP 800-22 test chain.
//  - Producer side of the serial random-bit interface that the NIST test block consumes.
//  - Emits one framed test sequence of SEQ_LEN bits per start request: known-answer patterns or a seeded LFSR.
//  - Lets the bench and on-chip self-test drive the error flags with known pass/fail stimulus, independent of the ALFSR.
// PARAMETERS
//  SEQ_LEN   128       bits per emitted sequence (>=2)
//  IDX_W     8         width of bit index counter; must satisfy 2**IDX_W >= SEQ_LEN
//  SEED_DFLT 16'hACE1  LFSR seed substituted when the supplied seed is zero
// PORTS
//  clk        in   1      single clock; all logic rising-edge
//  rst        in   1      synchronous, active-high reset
//  start      in   1      request a new sequence; honoured only in IDLE
//  mode       in   3      pattern select, sampled on accepted start
//  seed       in   16     LFSR seed, sampled on accepted start
//  bit_out    out  1      current stream bit
//  bit_valid  out  1      bit_out holds a valid bit
//  bit_ready  in   1      consumer accepts bit; transfer = bit_valid & bit_ready
//  seq_first  out  1      qualifies bit index 0 (while bit_valid)
//  seq_last   out  1      qualifies bit index SEQ_LEN-1 (while bit_valid)
//  busy       out  1      high in LOAD and RUN
//  done       out  1      one-cycle pulse after the last transfer
// BEHAVIOUR
//  - Reset (in any state, including mid-sequence):
//    - state=IDLE; all outputs 0; bit index=0; LFSR=SEED_DFLT.
//    - A partially sent sequence is abandoned; there is no resume.
//  - FSM states and transitions:
//    - IDLE->LOAD on start: latch mode; LFSR <= (seed==0 ? SEED_DFLT : seed).
//    - LOAD->RUN after 1 cycle; bit_valid rises on RUN entry (latency start->first valid = 2 clk).
//    - RUN->DONE on transfer with index==SEQ_LEN-1.
//    - DONE->IDLE after 1 cycle; done=1 only in DONE.
//    - start outside IDLE is ignored (no queuing). mode/seed changes after acceptance have no effect.
//  - Handshake:
//    - bit_out, seq_first and seq_last are stable while bit_valid & !bit_ready.
//    - On each transfer: index+1, and the pattern generator advances exactly one step.
//    - No step occurs without a transfer.
//    - bit_valid stays 1 for the whole of RUN (no bubbles); bit_ready is ignored outside RUN.
//  - Patterns (i = bit index, L = 16-bit LFSR):
//    - 0: all zeros
//    - 1: all ones
//    - 2: alternating, bit = i[0] (0,1,0,1...)
//    - 3: LFSR, bit = L[15]; step L <= {L[14:0], L[15]^L[13]^L[12]^L[10]} (x^16+x^14+x^13+x^11+1)
//    - 4: biased LFSR, bit = L[15]&L[14] (P(1)~0.25); same step as mode 3
//    - 5: long runs, bit = ~i[3] (8 ones, 8 zeros, repeating)
//    - 6,7: reserved, emit zeros
//  - Index is IDX_W bits, no wrap within a sequence; cleared in IDLE.
//  - Mode 3 and mode 4 with an identical seed use identical LFSR state sequences.
// STRUCTURE
//  - Shared package nist_pkg:
//    - mode encodings (MODE_ZERO..MODE_RUNS)
//    - FSM state enum (IDLE, LOAD, RUN, DONE)
//    - LFSR tap constants and SEED_DFLT
//  - One sub-module nist_lfsr16: load/step enables, 16-bit state output; reused by self-test logic.
//  - Everything else (FSM, index counter, pattern mux) stays in this module.
// TESTING
//  - mode=0, ready=1 always, start pulse:
//    - 128 transfers, all 0; seq_first on transfer 0, seq_last on transfer 127.
//    - done pulses exactly 1 cycle later; busy low after done.
//  - mode=3, seed=16'hACE1:
//    - first bits 1,0; LFSR state after first transfer = 16'h59C3.
//    - seed=0 produces the bit-identical stream.
//  - mode=2 with bit_ready toggling pseudo-randomly:
//    - received stream exactly 0,1,0,1...; bit_out never changes while valid & !ready.
//  - Assert rst during RUN at index 40:
//    - next cycle all outputs 0, state IDLE.
//    - A new start restarts from index 0 with seq_first.
//  - start pulses during LOAD/RUN/DONE: no effect on the count; exactly one sequence and one done produced.
//  - mode=5: first 16 bits 1111111100000000; mode=7: all zeros.

Source files
------------

// File: rtl/nist_pkg.sv
// Shared definitions for the NIST SP 800-22 bit-stream source.
// Holds the mode encodings, FSM states, LFSR taps and default seed, plus the LFSR and pattern helpers.
package nist_pkg;

  localparam logic [2:0] MODE_ZERO = 3'd0;
  localparam logic [2:0] MODE_ONE  = 3'd1;
  localparam logic [2:0] MODE_ALT  = 3'd2;
  localparam logic [2:0] MODE_LFSR = 3'd3;
  localparam logic [2:0] MODE_BIAS = 3'd4;
  localparam logic [2:0] MODE_RUNS = 3'd5;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

  // Fibonacci taps for x^16+x^14+x^13+x^11+1, i.e. state bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [15:0] SEED_DFLT = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], ^(l & LFSR_TAPS)};
  endfunction

  // idx_lo carries bit index [3:0]; modes 2 and 5 only look at bits 0 and 3.
  function automatic logic pattern_bit(input logic [2:0] mode, input logic [3:0] idx_lo,
                                       input logic [15:0] l);
    logic b;
    b = 1'b0;
    case (mode)
      MODE_ZERO: b = 1'b0;
      MODE_ONE:  b = 1'b1;
      MODE_ALT:  b = idx_lo[0];
      MODE_LFSR: b = l[15];
      MODE_BIAS: b = l[15] & l[14];
      MODE_RUNS: b = ~idx_lo[3];
      default:   b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/nist_lfsr16.sv
// 16-bit Fibonacci LFSR with load and step enables; a zero seed is replaced by SEED_DFLT.
// Load has priority over step.
module nist_lfsr16
  import nist_pkg::*;
#(
  parameter logic [15:0] SEED_DFLT_P = SEED_DFLT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic [15:0] i_seed,
  input  logic        i_step,
  output logic [15:0] o_state
);

  logic [15:0] r_state;

  // An all-zero state would lock up the register, so it is never loaded.
  always_ff @(posedge clk) begin
    if (rst)         r_state <= SEED_DFLT_P;
    else if (i_load) r_state <= (i_seed == 16'h0000) ? SEED_DFLT_P : i_seed;
    else if (i_step) r_state <= lfsr_next(r_state);
  end

  assign o_state = r_state;

endmodule

// File: rtl/nist_pattern_source.sv
// Framed serial bit source feeding the NIST test chain: one SEQ_LEN-bit sequence per start.
// Valid/ready producer; the pattern generator advances only on a transfer.
module nist_pattern_source
  import nist_pkg::*;
#(
  parameter int          SEQ_LEN     = 128,
  parameter int          IDX_W       = 8,
  parameter logic [15:0] SEED_DFLT_P = SEED_DFLT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  mode,
  input  logic [15:0] seed,
  output logic        bit_out,
  output logic        bit_valid,
  input  logic        bit_ready,
  output logic        seq_first,
  output logic        seq_last,
  output logic        busy,
  output logic        done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEQ_LEN - 1);

  state_e           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [2:0]       r_mode;
  logic             r_valid;
  logic             r_busy;
  logic             r_done;

  logic        w_xfer;
  logic        w_load;
  logic        w_last;
  logic        w_pat;
  logic [15:0] w_lfsr;

  // r_valid is set only while in RUN, so it alone qualifies a transfer.
  assign w_xfer = r_valid & bit_ready;
  assign w_load = (r_state == IDLE) & start;
  assign w_last = (r_idx == LAST_IDX);

  nist_lfsr16 #(.SEED_DFLT_P(SEED_DFLT_P)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_seed  (seed),
    .i_step  (w_xfer),
    .o_state (w_lfsr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_mode  <= MODE_ZERO;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_idx <= '0;
          if (start) begin
            r_mode  <= mode;
            r_busy  <= 1'b1;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_valid <= 1'b1;
          r_state <= RUN;
        end
        RUN: begin
          if (w_xfer) begin
            r_idx <= r_idx + 1'b1;
            if (w_last) begin
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_pat = pattern_bit(r_mode, r_idx[3:0], w_lfsr);

  // Outputs are built only from registers, so they hold steady across stalls.
  assign bit_out   = r_valid & w_pat;
  assign bit_valid = r_valid;
  assign seq_first = r_valid & (r_idx == '0);
  assign seq_last  = r_valid & w_last;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_nist_pattern_source.sv
// Directed bench for nist_pattern_source: known-answer patterns, handshake stalls,
// mid-run reset and ignored start pulses, all checked against bench-side expectations.
module tb_nist_pattern_source;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  mode;
  logic [15:0] seed;
  logic        bit_out, bit_valid, bit_ready, seq_first, seq_last, busy, done;

  nist_pattern_source dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .seed      (seed),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .seq_first (seq_first),
    .seq_last  (seq_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  bit rx  [0:299];
  bit ex  [0:127];
  bit sav [0:127];
  int nrx, n_first, first_pos, n_last, last_pos, n_done, done_gap, n_unstable, xfer_cyc;

  // Expected stream straight from the pattern table.
  task automatic build_exp(input logic [2:0] m, input logic [15:0] s);
    logic [15:0] l;
    l = (s == 16'h0) ? 16'hACE1 : s;
    for (int i = 0; i < 128; i++) begin
      case (m)
        3'd1:    ex[i] = 1'b1;
        3'd2:    ex[i] = (i % 2) == 1;
        3'd3:    ex[i] = l[15];
        3'd4:    ex[i] = l[15] & l[14];
        3'd5:    ex[i] = ((i / 8) % 2) == 0;
        default: ex[i] = 1'b0;
      endcase
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    end
  endtask

  function automatic int mism();
    int n;
    n = 0;
    for (int i = 0; i < 128; i++) if (rx[i] != ex[i]) n++;
    return n;
  endfunction

  // One full sequence. Inputs change and outputs are sampled on the falling edge.
  task automatic run_seq(input logic [2:0] m, input logic [15:0] s, input bit rnd, input bit poke);
    bit         hold;
    logic [2:0] held;
    logic       r;
    nrx = 0; n_first = 0; first_pos = -1; n_last = 0; last_pos = -1;
    n_done = 0; done_gap = -1; n_unstable = 0; xfer_cyc = -100; hold = 0; held = '0;
    @(negedge clk);
    mode = m; seed = s; start = 1'b1;
    @(negedge clk);
    start = poke; mode = ~m; seed = ~s;
    chk("load_busy", busy, 1);
    chk("load_novalid", bit_valid, 0);
    @(negedge clk);
    chk("first_valid_lat2", bit_valid, 1);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (hold && ({bit_out, seq_first, seq_last} !== held)) n_unstable++;
      if (done) begin
        n_done++;
        if (done_gap < 0) done_gap = cyc - xfer_cyc;
      end
      if (n_done > 0 && cyc > xfer_cyc + 4) break;
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bit_ready = r;
      start = poke && (busy || done) ? 1'($urandom_range(0, 1)) : 1'b0;
      hold = bit_valid && !r;
      held = {bit_out, seq_first, seq_last};
      if (bit_valid && r) begin
        if (nrx < 300) rx[nrx] = bit_out;
        if (seq_first) begin n_first++; first_pos = nrx; end
        if (seq_last)  begin n_last++;  last_pos  = nrx; end
        nrx++;
        xfer_cyc = cyc;
      end
      @(negedge clk);
    end
    start = 1'b0;
    bit_ready = 1'b0;
    chk("end_busy_low", busy, 0);
    chk("end_done_low", done, 0);
  endtask

  initial begin
    int cnt;
    logic [15:0] w;
    rst = 1'b1; start = 1'b0; mode = '0; seed = '0; bit_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {bit_out, bit_valid, seq_first, seq_last, busy, done}, 0);
    rst = 1'b0;

    // mode 0, always ready
    run_seq(3'd0, 16'h1234, 1'b0, 1'b0);
    build_exp(3'd0, 16'h1234);
    chk("m0_count", nrx, 128);
    chk("m0_bits", mism(), 0);
    chk("m0_first_n", n_first, 1);
    chk("m0_first_pos", first_pos, 0);
    chk("m0_last_n", n_last, 1);
    chk("m0_last_pos", last_pos, 127);
    chk("m0_done_n", n_done, 1);
    chk("m0_done_gap", done_gap, 1);

    // mode 3, seed ACE1: bits 1..16 spell the state after one step
    run_seq(3'd3, 16'hACE1, 1'b0, 1'b0);
    build_exp(3'd3, 16'hACE1);
    chk("m3_bit0", rx[0], 1);
    chk("m3_bit1", rx[1], 0);
    for (int i = 0; i < 16; i++) w[15-i] = rx[1+i];
    chk("m3_state_after1", w, 16'h59C3);
    chk("m3_bits", mism(), 0);
    for (int i = 0; i < 128; i++) sav[i] = rx[i];

    // zero seed must reproduce the default-seed stream
    run_seq(3'd3, 16'h0000, 1'b0, 1'b0);
    cnt = 0;
    for (int i = 0; i < 128; i++) if (rx[i] != sav[i]) cnt++;
    chk("m3_seed0_same", cnt, 0);

    run_seq(3'd4, 16'hACE1, 1'b0, 1'b0);
    build_exp(3'd4, 16'hACE1);
    chk("m4_bits", mism(), 0);

    // mode 2 under random back-pressure
    run_seq(3'd2, 16'h0001, 1'b1, 1'b0);
    build_exp(3'd2, 16'h0001);
    chk("m2_count", nrx, 128);
    chk("m2_bits", mism(), 0);
    chk("m2_stable", n_unstable, 0);
    chk("m2_done_n", n_done, 1);

    run_seq(3'd5, 16'h0001, 1'b0, 1'b0);
    build_exp(3'd5, 16'h0001);
    for (int i = 0; i < 16; i++) w[15-i] = rx[i];
    chk("m5_first16", w, 16'hFF00);
    chk("m5_bits", mism(), 0);

    run_seq(3'd7, 16'hFFFF, 1'b0, 1'b0);
    build_exp(3'd7, 16'hFFFF);
    chk("m7_bits", mism(), 0);

    // start pokes while busy or done must not disturb anything
    run_seq(3'd1, 16'h0001, 1'b1, 1'b1);
    build_exp(3'd1, 16'h0001);
    chk("poke_count", nrx, 128);
    chk("poke_bits", mism(), 0);
    chk("poke_done_n", n_done, 1);
    repeat (3) @(negedge clk);
    chk("poke_idle_after", busy, 0);

    // reset at index 40, then a clean restart
    @(negedge clk);
    mode = 3'd2; seed = 16'h0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; bit_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (cnt == 40) break;
      if (bit_valid) cnt++;
    end
    chk("rst40_reached", cnt, 40);
    chk("rst40_valid", bit_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst40_outputs", {bit_out, bit_valid, seq_first, seq_last, busy, done}, 0);
    rst = 1'b0;
    bit_ready = 1'b0;
    run_seq(3'd2, 16'h0, 1'b0, 1'b0);
    build_exp(3'd2, 16'h0);
    chk("restart_first_pos", first_pos, 0);
    chk("restart_count", nrx, 128);
    chk("restart_bits", mism(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
